// File: rtl/duty_seq_pkg.sv
// Shared definitions for the duty-cycle sequencer: logic levels, gain format
// and the sequencer state encoding.
package duty_seq_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;
  localparam logic ON   = 1'b1;
  localparam logic OFF  = 1'b0;

  // Gain is unsigned Q1.7: 128 represents unity.
  localparam int GAIN_W     = 8;
  localparam int GAIN_SHIFT = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/zDutyRam.sv
// Duty table: synchronous write, registered read; a same-address write and
// read in one cycle returns the previous contents.
module zDutyRam #(
  parameter int pWIDTH = 10,
  parameter int pAW    = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [pAW-1:0]    wr_addr,
  input  logic [pWIDTH-1:0] wr_data,
  input  logic [pAW-1:0]    rd_addr,
  output logic [pWIDTH-1:0] rd_data
);

  logic [pWIDTH-1:0] mem [2**pAW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/duty_seq.sv
// Table-driven duty sequencer: plays table entries to the PWM one per period,
// scaled by a Q1.7 gain and saturated at the PWM period.
module duty_seq
  import duty_seq_pkg::*;
#(
  parameter int pWIDTH = 10,
  parameter int pAW    = 7,
  parameter int pMAX   = 210
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              end_tick,
  input  logic [pAW-1:0]    len,
  input  logic [GAIN_W-1:0] gain,
  input  logic              wr_en,
  input  logic [pAW-1:0]    wr_addr,
  input  logic [pWIDTH-1:0] wr_data,
  output logic [pWIDTH-1:0] cyc_duty,
  output logic [pAW-1:0]    index,
  output logic              wrap_tick,
  output logic              busy
);

  localparam int PW = pWIDTH + GAIN_W;
  localparam logic [PW-1:0]     MAX_P = PW'(pMAX);
  localparam logic [pWIDTH-1:0] MAX_D = pWIDTH'(pMAX);

  function automatic logic [pWIDTH-1:0] sat(input logic [PW-1:0] prod);
    logic [PW-1:0] shifted;
    shifted = prod >> GAIN_SHIFT;
    if (shifted > MAX_P) return MAX_D;
    return shifted[pWIDTH-1:0];
  endfunction

  state_t            state, state_nxt;
  logic              advance;
  logic              wrap;
  logic              load_fire;
  logic [pAW-1:0]    idx_next;
  logic [pAW-1:0]    rd_addr;
  logic [pWIDTH-1:0] rd_data;
  logic [PW-1:0]     prod_p0;
  logic              vld_p0;

  zDutyRam #(.pWIDTH(pWIDTH), .pAW(pAW)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_nxt = state;
    advance   = LOW;
    case (state)
      ST_IDLE:  if (en) state_nxt = ST_PRIME;
      ST_PRIME: state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_RUN;
      ST_RUN: begin
        if (end_tick) begin
          advance   = HIGH;
          state_nxt = ST_LOAD;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
    if (!en) begin
      state_nxt = ST_IDLE;
      advance   = LOW;
    end
  end

  // A lowered len below the current index still wraps because of the >= test.
  assign wrap      = advance && (index >= len);
  assign idx_next  = wrap ? '0 : index + 1'b1;
  assign rd_addr   = advance ? idx_next : index;
  assign load_fire = (state == ST_LOAD) && en;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      index     <= '0;
      wrap_tick <= LOW;
      vld_p0    <= OFF;
      cyc_duty  <= '0;
    end else begin
      state     <= state_nxt;
      wrap_tick <= wrap;
      vld_p0    <= load_fire ? ON : OFF;
      if (!en) begin
        index    <= '0;
        cyc_duty <= '0;
      end else begin
        if (advance) index <= idx_next;
        if (vld_p0) cyc_duty <= sat(prod_p0);
      end
    end
  end

  // p0: table word times gain, one cycle after the registered read lands
  always_ff @(posedge clk) begin
    if (load_fire) prod_p0 <= {{GAIN_W{1'b0}}, rd_data} * {{pWIDTH{1'b0}}, gain};
  end

endmodule
